button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised, multi-channel conditioner for the board push-buttons (BtnU/BtnD/BtnL/BtnR/BtnC and any later switches).
- Per channel it does four things: synchronises the raw pin, debounces it, produces press/release pulses, and generates an optional auto-repeat "move" pulse while the button is held.
- Sits between the top-level pins and the game logic. Replaces the empty input-interface stub.
- The game FSM consumes one-cycle move pulses instead of sampling raw buttons on a divided clock.

Parameters:
- N_CH, 5, number of independent input channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥2.
- REPEAT_DELAY, 40000000, cycles from accepted press to first auto-repeat pulse; legal range ≥1.
- REPEAT_PERIOD, 15000000, cycles between subsequent auto-repeat pulses; legal range ≥1.
- REPEAT_EN_MASK, {N_CH{1'b1}}, per-channel static auto-repeat enable.
- CNT_W, derived as clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1), counter width.

Ports:
- clk  input  1  system clock (100 MHz ClkPort domain).
- reset  input  1  synchronous, active-low reset.
- raw_in  input  N_CH  asynchronous button/switch levels, 1 = pressed.
- level_out  output  N_CH  debounced level.
- press_pulse  output  N_CH  one-cycle pulse on accepted 0→1.
- release_pulse  output  N_CH  one-cycle pulse on accepted 1→0.
- move_pulse  output  N_CH  press_pulse OR auto-repeat pulse.
- any_held  output  1  OR-reduction of level_out.

Behaviour:
- Reset (reset==0 at a clk edge): sync flops, level_out, all counters, all pulses and any_held are cleared to 0; each repeat FSM goes to IDLE. Reset dominates every other event in the same cycle.
- Synchroniser: two flops per channel (s1, s2). s2 reflects raw_in two edges later.
- Debounce, per channel:
  - dcnt counts edges where s2 != level_out.
  - dcnt clears to 0 on any edge where s2 == level_out, so a glitch restarts the count.
  - When s2 != level_out and dcnt == DEBOUNCE_CYCLES-1, level_out toggles and dcnt clears.
  - Latency: a clean raw step at edge k appears on level_out after edge k+1+DEBOUNCE_CYCLES.
- Pulses are registered. press_pulse and release_pulse go high in the first cycle the new level_out is visible and stay high for exactly one cycle.
- Repeat FSM, per channel (states IDLE, DELAY, REPEAT; rcnt counter):
  - IDLE: on accepted press → DELAY, rcnt=0.
  - DELAY: rcnt increments. At rcnt==REPEAT_DELAY-1, emit repeat pulse, rcnt=0, go to REPEAT.
  - REPEAT: rcnt increments. At rcnt==REPEAT_PERIOD-1, emit repeat pulse and rcnt=0.
  - From DELAY or REPEAT: accepted release → IDLE, rcnt=0, no pulse that cycle.
  - Channel with REPEAT_EN_MASK bit 0: stays in IDLE permanently.
- move_pulse = press_pulse | repeat pulse. The two never coincide, since a repeat pulse needs ≥1 cycle in DELAY.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses. There is no priority or arbitration.
- Counters saturate nowhere: every count path clears at its terminal value, so no wrap-around is reachable.
- Reset mid-hold: all outputs return to 0. If the button is still held after reset, it is re-debounced and yields a fresh press_pulse.
- any_held is registered and equals |level_out, with the same timing as level_out.

Decomposition:
- Shared package input_pkg holds:
  - the repeat-FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2);
  - the default timing constants for 100 MHz;
  - a clog2 function.
- Sub-module button_channel holds one channel's synchroniser, debouncer, pulse generation and repeat FSM. It has scalar ports and takes DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD/REPEAT_EN parameters.
- Top instantiates N_CH button_channel copies in a generate loop and computes any_held.

Test Plan (N_CH=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_EN_MASK=5'b01111):
- Reset: hold reset=0 for 3 edges with raw_in=5'b11111 → all outputs 0; after reset=1, level_out=5'b11111 visible after edge 1+4 and press_pulse=5'b11111 for one cycle.
- Bounce: raw_in[0] toggles 1,0,1,0 on consecutive edges, then holds 1 → exactly one press_pulse[0], 5 edges after the final rising step; no pulse during the bounce.
- Glitch: raw_in[1] high for exactly 3 cycles → level_out[1], press_pulse[1] and move_pulse[1] never assert.
- Auto-repeat: hold raw_in[2]=1 long → move_pulse[2] at press, then 10 cycles later, then every 5 cycles; on release, release_pulse[2] once and no further move_pulse[2].
- Mask: hold raw_in[4]=1 for 50 cycles → single move_pulse[4] at press, no repeats; any_held=1 throughout.
- Reset mid-repeat: channel 3 in REPEAT, assert reset=0 one edge while still held → outputs clear; after release of reset, a fresh press_pulse[3] after 5 edges and first repeat 10 cycles later.

Source files
------------

// File: rtl/input_pkg.sv
// Shared types, default 100 MHz timing and helper functions for the push-button conditioner.
package input_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 40000000;
   localparam int DEF_REPEAT_PERIOD   = 15000000;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debouncer, press/release pulses and auto-repeat FSM.
//
// state      | meaning
// RPT_IDLE   | button released (or repeat disabled); waiting for an accepted press
// RPT_DELAY  | held; counting the initial delay before the first repeat pulse
// RPT_REPEAT | held; emitting a repeat pulse every REPEAT_PERIOD cycles
module button_channel
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_EN       = 1'b1,
   parameter int CNT_W           = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic level_nxt,
   output logic press_pulse,
   output logic release_pulse,
   output logic move_pulse
);

   localparam logic [CNT_W-1:0] DB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_TC  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_TC  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s1, s2;
   logic [CNT_W-1:0] dcnt;
   logic             db_hit, press_evt, rel_evt;
   rpt_state_t       state, state_nxt;
   logic [CNT_W-1:0] rcnt, rcnt_nxt;
   logic             rep_pulse, rep_nxt;

   assign db_hit    = (s2 != level) && (dcnt == DB_TC);
   assign press_evt = db_hit & s2;
   assign rel_evt   = db_hit & ~s2;
   assign level_nxt = db_hit ? s2 : level;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         level         <= 1'b0;
         dcnt          <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         s1            <= raw;
         s2            <= s1;
         level         <= level_nxt;
         press_pulse   <= press_evt;
         release_pulse <= rel_evt;
         // Any sample agreeing with the accepted level restarts the stability count.
         if (s2 == level || db_hit) dcnt <= '0;
         else                       dcnt <= dcnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= RPT_IDLE;
         rcnt      <= '0;
         rep_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         rcnt      <= rcnt_nxt;
         rep_pulse <= rep_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rep_nxt   = 1'b0;
      case (state)
         RPT_IDLE: begin
            if (REPEAT_EN && press_evt) begin
               state_nxt = RPT_DELAY;
               rcnt_nxt  = '0;
            end
         end
         RPT_DELAY: begin
            if (rel_evt) begin
               state_nxt = RPT_IDLE;
               rcnt_nxt  = '0;
            end else if (rcnt == RD_TC) begin
               state_nxt = RPT_REPEAT;
               rcnt_nxt  = '0;
               rep_nxt   = 1'b1;
            end else begin
               rcnt_nxt = rcnt + CNT_ONE;
            end
         end
         RPT_REPEAT: begin
            // A release landing on the terminal count wins; no trailing repeat pulse.
            if (rel_evt) begin
               state_nxt = RPT_IDLE;
               rcnt_nxt  = '0;
            end else if (rcnt == RP_TC) begin
               rcnt_nxt = '0;
               rep_nxt  = 1'b1;
            end else begin
               rcnt_nxt = rcnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
         end
      endcase
   end

   assign move_pulse = press_pulse | rep_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: N_CH independent button_channel instances plus any_held.
module button_conditioner
   import input_pkg::*;
#(
   parameter int              N_CH            = 5,
   parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int              REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int              REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter logic [N_CH-1:0] REPEAT_EN_MASK  = {N_CH{1'b1}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] move_pulse,
   output logic            any_held
);

   localparam int CNT_W = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [N_CH-1:0] level_nxt;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_EN_MASK[i]),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .raw           (raw_in[i]),
         .level         (level_out[i]),
         .level_nxt     (level_nxt[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .move_pulse    (move_pulse[i])
      );
   end

   // Registered from the channels' next-level so it tracks level_out with identical timing.
   always_ff @(posedge clk) begin
      if (!reset) any_held <= 1'b0;
      else        any_held <= |level_nxt;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (D=4, repeat delay 10, period 5, mask 01111).
module tb_button_conditioner;

   localparam int N = 5;

   logic         clk;
   logic         reset;
   logic [N-1:0] raw_in;
   logic [N-1:0] level_out, press_pulse, release_pulse, move_pulse;
   logic         any_held;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .N_CH            (N),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5),
      .REPEAT_EN_MASK  (5'b01111)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .raw_in        (raw_in),
      .level_out     (level_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .move_pulse    (move_pulse),
      .any_held      (any_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge; one tick = one rising edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      raw_in = '0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   // A raw step sampled at rising edge k is visible after edge k+5, i.e. on the 6th tick.
   task automatic test_reset();
      logic [4*N:0] all_out;
      reset  = 1'b0;
      raw_in = '1;
      repeat (3) tick();
      all_out = {level_out, press_pulse, release_pulse, move_pulse, any_held};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_clear got %b want all zero", all_out);
      end
      reset = 1'b1;
      repeat (5) tick();
      checks++;
      if (level_out !== 5'b00000 || press_pulse !== 5'b00000 || any_held !== 1'b0) begin
         errors++;
         $display("FAIL reset_early got level=%b press=%b held=%b want 00000 00000 0",
                  level_out, press_pulse, any_held);
      end
      tick();
      checks++;
      if (level_out !== 5'b11111 || press_pulse !== 5'b11111 || move_pulse !== 5'b11111
          || release_pulse !== 5'b00000 || any_held !== 1'b1) begin
         errors++;
         $display("FAIL reset_press got level=%b press=%b move=%b rel=%b held=%b want 11111 11111 11111 00000 1",
                  level_out, press_pulse, move_pulse, release_pulse, any_held);
      end
      tick();
      checks++;
      if (level_out !== 5'b11111 || press_pulse !== 5'b00000 || move_pulse !== 5'b00000) begin
         errors++;
         $display("FAIL reset_one_cycle got level=%b press=%b move=%b want 11111 00000 00000",
                  level_out, press_pulse, move_pulse);
      end
   endtask

   task automatic test_bounce();
      int bounce_press = 0;
      int n_press      = 0;
      int first_t      = -1;
      logic [3:0] pattern = 4'b0101;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         raw_in[0] = pattern[i];
         tick();
         if (press_pulse[0]) bounce_press++;
      end
      raw_in[0] = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (press_pulse[0]) begin
            n_press++;
            if (first_t < 0) first_t = t;
         end
      end
      checks++;
      if (bounce_press !== 0) begin
         errors++;
         $display("FAIL bounce_quiet got %0d pulses want 0", bounce_press);
      end
      checks++;
      if (n_press !== 1 || first_t !== 6) begin
         errors++;
         $display("FAIL bounce_press got count=%0d at t=%0d want count=1 at t=6", n_press, first_t);
      end
      checks++;
      if (level_out[0] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_level got %b want 1", level_out[0]);
      end
   endtask

   // Three high samples get the count to DEBOUNCE_CYCLES-1 but never to acceptance.
   task automatic test_glitch();
      logic seen = 1'b0;
      do_reset();
      raw_in[1] = 1'b1;
      for (int t = 1; t <= 15; t++) begin
         tick();
         if (t == 3) raw_in[1] = 1'b0;
         seen = seen | level_out[1] | press_pulse[1] | move_pulse[1] | any_held;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL glitch_reject got %b want 0", seen);
      end
   endtask

   // Press at t=6, repeats at 16,21,...,41; release accepted at t=46 swallows the repeat due then.
   task automatic test_auto_repeat();
      logic exp_move, exp_press, exp_rel;
      do_reset();
      raw_in[2] = 1'b1;
      for (int t = 1; t <= 60; t++) begin
         tick();
         exp_move  = (t == 6) || (t == 16) || (t == 21) || (t == 26) || (t == 31)
                     || (t == 36) || (t == 41);
         exp_press = (t == 6);
         exp_rel   = (t == 46);
         checks++;
         if (move_pulse[2] !== exp_move || press_pulse[2] !== exp_press
             || release_pulse[2] !== exp_rel) begin
            errors++;
            $display("FAIL repeat_t%0d got move=%b press=%b rel=%b want %b %b %b",
                     t, move_pulse[2], press_pulse[2], release_pulse[2],
                     exp_move, exp_press, exp_rel);
         end
         if (t == 40) raw_in[2] = 1'b0;
      end
   endtask

   task automatic test_mask();
      logic exp_move, exp_held, exp_rel;
      do_reset();
      raw_in[4] = 1'b1;
      for (int t = 1; t <= 56; t++) begin
         tick();
         exp_move = (t == 6);
         exp_held = (t >= 6);
         checks++;
         if (move_pulse[4] !== exp_move || any_held !== exp_held) begin
            errors++;
            $display("FAIL mask_hold_t%0d got move=%b held=%b want %b %b",
                     t, move_pulse[4], any_held, exp_move, exp_held);
         end
      end
      raw_in[4] = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         exp_rel  = (t == 6);
         exp_held = (t < 6);
         checks++;
         if (release_pulse[4] !== exp_rel || any_held !== exp_held || move_pulse[4] !== 1'b0) begin
            errors++;
            $display("FAIL mask_release_t%0d got rel=%b held=%b move=%b want %b %b 0",
                     t, release_pulse[4], any_held, move_pulse[4], exp_rel, exp_held);
         end
      end
   endtask

   task automatic test_reset_mid_repeat();
      logic [4*N:0] all_out;
      logic exp_move, exp_press;
      do_reset();
      raw_in[3] = 1'b1;
      repeat (20) tick();
      checks++;
      if (level_out[3] !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre got level=%b want 1", level_out[3]);
      end
      reset = 1'b0;
      tick();
      all_out = {level_out, press_pulse, release_pulse, move_pulse, any_held};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL midrst_clear got %b want all zero", all_out);
      end
      reset = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         exp_press = (t == 6);
         exp_move  = (t == 6) || (t == 16);
         checks++;
         if (press_pulse[3] !== exp_press || move_pulse[3] !== exp_move
             || level_out[3] !== (t >= 6)) begin
            errors++;
            $display("FAIL midrst_t%0d got press=%b move=%b level=%b want %b %b %b",
                     t, press_pulse[3], move_pulse[3], level_out[3],
                     exp_press, exp_move, (t >= 6));
         end
      end
      raw_in = '0;
   endtask

   initial begin
      reset  = 1'b0;
      raw_in = '0;
      test_reset();
      test_bounce();
      test_glitch();
      test_auto_repeat();
      test_mask();
      test_reset_mid_repeat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
